// File: rtl/mem_arbiter.sv
// Arbitrates one single-outstanding memory port between instruction fetch and data access.
// Data wins every issue slot; redirects flag the in-flight fetch so its response is dropped.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_valid,
    input  logic            imem_spec,
    input  logic            imem_fence,
    input  logic [1:0]      imem_mode,
    input  logic [XLEN-1:0] imem_addr,
    output logic            imem_ready,
    output logic [XLEN-1:0] imem_rdata,
    input  logic            dmem_valid,
    input  logic [1:0]      dmem_mode,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [3:0]      dmem_wstrb,
    output logic            dmem_ready,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            mem_valid,
    output logic            mem_fence,
    output logic            mem_instr,
    output logic [1:0]      mem_mode,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t            state_q, state_d;
    logic              ipend_q, ipend_d, ifence_q, ifence_d;
    logic [1:0]        imode_q, imode_d;
    logic [XLEN-1:0]   iaddr_q, iaddr_d;
    logic              dpend_q, dpend_d;
    logic [1:0]        dmode_q, dmode_d;
    logic [XLEN-1:0]   daddr_q, daddr_d, dwdata_q, dwdata_d;
    logic [3:0]        dwstrb_q, dwstrb_d;
    logic              discard_q, discard_d;
    logic              slot, redirect;

    always_comb begin
        state_d    = state_q;
        ipend_d    = ipend_q;
        ifence_d   = ifence_q;
        imode_d    = imode_q;
        iaddr_d    = iaddr_q;
        dpend_d    = dpend_q;
        dmode_d    = dmode_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        dwstrb_d   = dwstrb_q;
        discard_d  = discard_q;
        imem_ready = 1'b0;
        imem_rdata = '0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        mem_valid  = 1'b0;
        mem_fence  = 1'b0;
        mem_instr  = 1'b0;
        mem_mode   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;
        slot       = (state_q == IDLE) || mem_ready;
        redirect   = imem_valid && imem_spec;

        // Everything is gated by rst so a reset cycle issues and completes nothing.
        if (rst) begin
            if (state_q == DBUSY && mem_ready) begin
                dmem_ready = 1'b1;
                dmem_rdata = mem_rdata;
            end
            if (state_q == IBUSY) begin
                if (mem_ready) begin
                    discard_d = 1'b0;
                    if (!discard_q && !redirect) begin
                        imem_ready = 1'b1;
                        imem_rdata = mem_rdata;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            if (slot) state_d = IDLE;

            // Capture first; an issue below in the same cycle clears the slot again.
            if (imem_valid) begin
                ipend_d  = 1'b1;
                iaddr_d  = imem_addr;
                imode_d  = imem_mode;
                ifence_d = imem_fence;
            end
            if (dmem_valid) begin
                dpend_d  = 1'b1;
                daddr_d  = dmem_addr;
                dmode_d  = dmem_mode;
                dwdata_d = dmem_wdata;
                dwstrb_d = dmem_wstrb;
            end

            if (slot && (dmem_valid || dpend_q)) begin
                mem_valid = 1'b1;
                mem_addr  = dmem_valid ? dmem_addr  : daddr_q;
                mem_mode  = dmem_valid ? dmem_mode  : dmode_q;
                mem_wdata = dmem_valid ? dmem_wdata : dwdata_q;
                mem_wstrb = dmem_valid ? dmem_wstrb : dwstrb_q;
                dpend_d   = 1'b0;
                state_d   = DBUSY;
            end else if (slot && (imem_valid || ipend_q)) begin
                mem_valid = 1'b1;
                mem_instr = 1'b1;
                mem_addr  = imem_valid ? imem_addr  : iaddr_q;
                mem_mode  = imem_valid ? imem_mode  : imode_q;
                mem_fence = imem_valid ? imem_fence : ifence_q;
                ipend_d   = 1'b0;
                state_d   = IBUSY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            ipend_q   <= 1'b0;
            ifence_q  <= 1'b0;
            imode_q   <= '0;
            iaddr_q   <= '0;
            dpend_q   <= 1'b0;
            dmode_q   <= '0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dwstrb_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ipend_q   <= ipend_d;
            ifence_q  <= ifence_d;
            imode_q   <= imode_d;
            iaddr_q   <= iaddr_d;
            dpend_q   <= dpend_d;
            dmode_q   <= dmode_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            dwstrb_q  <= dwstrb_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: tasks drive the requesters and the memory side by hand,
// a scoreboard queue holds the responses each requester should eventually see.
module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_valid, imem_spec, imem_fence;
    logic [1:0]      imem_mode;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic            dmem_valid;
    logic [1:0]      dmem_mode;
    logic [XLEN-1:0] dmem_addr, dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;
    logic            mem_valid, mem_fence, mem_instr;
    logic [1:0]      mem_mode;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] exp_i[$];
    logic [XLEN-1:0] exp_d[$];

    always #5 clk = ~clk;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_spec(imem_spec), .imem_fence(imem_fence),
        .imem_mode(imem_mode), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_valid(dmem_valid), .dmem_mode(dmem_mode), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_valid(mem_valid), .mem_fence(mem_fence), .mem_instr(mem_instr),
        .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Response monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        #4;
        if (imem_ready) begin
            tests++;
            if (exp_i.size() == 0) begin
                fails++; $display("FAIL imem_resp unexpected: got %h, none expected", imem_rdata);
            end else begin
                logic [XLEN-1:0] e;
                e = exp_i.pop_front();
                if (imem_rdata !== e) begin
                    fails++; $display("FAIL imem_resp: got %h expected %h", imem_rdata, e);
                end
            end
        end
        if (dmem_ready) begin
            tests++;
            if (exp_d.size() == 0) begin
                fails++; $display("FAIL dmem_resp unexpected: got %h, none expected", dmem_rdata);
            end else begin
                logic [XLEN-1:0] e;
                e = exp_d.pop_front();
                if (dmem_rdata !== e) begin
                    fails++; $display("FAIL dmem_resp: got %h expected %h", dmem_rdata, e);
                end
            end
        end
    end

    task automatic idle_inputs();
        imem_valid = 0; imem_spec = 0; imem_fence = 0; imem_mode = 0; imem_addr = 0;
        dmem_valid = 0; dmem_mode = 0; dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    // Advance to the next drive point, with all strobes dropped.
    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1;
        #2;
        tests++;
        if ({imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_valid, mem_fence, mem_instr,
             mem_mode, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            fails++; $display("FAIL reset_outputs: mem_valid=%b imem_ready=%b dmem_ready=%b, all 0 expected",
                              mem_valid, imem_ready, dmem_ready);
        end
    endtask

    task automatic test_fetch();
        next_cycle();
        imem_valid = 1; imem_addr = 32'h100; imem_mode = 2'd3; imem_fence = 1;
        #2;
        tests++;
        if ({mem_valid, mem_instr, mem_fence, mem_mode, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 1'b1, 2'd3, 32'h100, 4'h0}) begin
            fails++; $display("FAIL fetch_issue: valid=%b instr=%b fence=%b mode=%0d addr=%h wstrb=%h",
                              mem_valid, mem_instr, mem_fence, mem_mode, mem_addr, mem_wstrb);
        end
        exp_i.push_back(32'h00000013);
        next_cycle();
        #2;
        tests++;
        if (mem_valid !== 1'b0 || imem_ready !== 1'b0) begin
            fails++; $display("FAIL fetch_wait: mem_valid=%b imem_ready=%b, expected 0/0", mem_valid, imem_ready);
        end
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h00000013;
        #2;
        tests++;
        if (imem_ready !== 1'b1 || imem_rdata !== 32'h13) begin
            fails++; $display("FAIL fetch_resp: ready=%b data=%h expected 1/00000013", imem_ready, imem_rdata);
        end
    endtask

    task automatic test_data_priority();
        next_cycle();
        imem_valid = 1; imem_addr = 32'h104;
        dmem_valid = 1; dmem_addr = 32'h2000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF; dmem_mode = 2'd1;
        #2;
        tests++;
        if ({mem_valid, mem_instr, mem_fence, mem_mode, mem_addr, mem_wdata, mem_wstrb} !==
            {1'b1, 1'b0, 1'b0, 2'd1, 32'h2000, 32'hDEADBEEF, 4'hF}) begin
            fails++; $display("FAIL prio_data_issue: valid=%b instr=%b addr=%h wdata=%h wstrb=%h",
                              mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb);
        end
        exp_d.push_back(32'h0);
        next_cycle();
        #2;
        tests++;
        if (mem_valid !== 1'b0) begin
            fails++; $display("FAIL prio_hold: mem_valid=%b expected 0", mem_valid);
        end
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h0;
        #2;
        tests++;
        if ({dmem_ready, mem_valid, mem_instr, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 1'b1, 32'h104, 4'h0}) begin
            fails++; $display("FAIL prio_fetch_issue: dready=%b valid=%b instr=%b addr=%h wstrb=%h",
                              dmem_ready, mem_valid, mem_instr, mem_addr, mem_wstrb);
        end
        exp_i.push_back(32'hA0A00104);
        next_cycle();
        next_cycle();
        mem_ready = 1; mem_rdata = 32'hA0A00104;
    endtask

    task automatic test_redirect();
        next_cycle();
        imem_valid = 1; imem_addr = 32'h108;
        #2;
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h108) begin
            fails++; $display("FAIL redir_issue: valid=%b addr=%h expected 1/00000108", mem_valid, mem_addr);
        end
        next_cycle();
        imem_valid = 1; imem_spec = 1; imem_addr = 32'h400;
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h0BAD0BAD;
        #2;
        tests++;
        if ({imem_ready, mem_valid, mem_instr, mem_addr} !== {1'b0, 1'b1, 1'b1, 32'h400}) begin
            fails++; $display("FAIL redir_drop: iready=%b valid=%b instr=%b addr=%h expected 0/1/1/00000400",
                              imem_ready, mem_valid, mem_instr, mem_addr);
        end
        exp_i.push_back(32'h0400C0DE);
        next_cycle();
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h0400C0DE;
        #2;
        tests++;
        if (imem_ready !== 1'b1) begin
            fails++; $display("FAIL redir_deliver: imem_ready=%b expected 1", imem_ready);
        end
    endtask

    task automatic test_spec_same_cycle();
        next_cycle();
        imem_valid = 1; imem_addr = 32'h200;
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h22222222;
        imem_valid = 1; imem_spec = 1; imem_addr = 32'h500;
        #2;
        tests++;
        if ({imem_ready, mem_valid, mem_instr, mem_addr} !== {1'b0, 1'b1, 1'b1, 32'h500}) begin
            fails++; $display("FAIL spec_same_cycle: iready=%b valid=%b addr=%h expected 0/1/00000500",
                              imem_ready, mem_valid, mem_addr);
        end
        exp_i.push_back(32'h55555555);
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h55555555;
        #2;
        tests++;
        if (imem_ready !== 1'b1 || imem_rdata !== 32'h55555555) begin
            fails++; $display("FAIL spec_no_discard: ready=%b data=%h expected 1/55555555", imem_ready, imem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        dmem_valid = 1; dmem_addr = 32'h3000; dmem_wstrb = 4'h0;
        exp_d.push_back(32'h000055AA);
        next_cycle();
        imem_valid = 1; imem_addr = 32'h10C;
        #2;
        tests++;
        if (mem_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_hold_10c: mem_valid=%b expected 0", mem_valid);
        end
        next_cycle();
        imem_valid = 1; imem_addr = 32'h110;
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h000055AA;
        #2;
        tests++;
        if ({dmem_ready, dmem_rdata, mem_valid, mem_instr, mem_addr} !== {1'b1, 32'h55AA, 1'b1, 1'b1, 32'h110}) begin
            fails++; $display("FAIL b2b_latest: dready=%b ddata=%h valid=%b addr=%h expected 1/000055aa/1/00000110",
                              dmem_ready, dmem_rdata, mem_valid, mem_addr);
        end
        exp_i.push_back(32'h00001100);
        next_cycle();
        mem_ready = 1; mem_rdata = 32'h00001100;
        next_cycle();
        #2;
        tests++;
        if (mem_valid !== 1'b0 || imem_rdata !== '0 || dmem_rdata !== '0) begin
            fails++; $display("FAIL b2b_no_stale: valid=%b irdata=%h drdata=%h expected 0/0/0",
                              mem_valid, imem_rdata, dmem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        next_cycle();
        imem_valid = 1; imem_addr = 32'h600;
        next_cycle();
        rst = 0;
        next_cycle();
        rst = 1;
        mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
        #2;
        tests++;
        if ({imem_ready, imem_rdata, dmem_ready, dmem_rdata, mem_valid, mem_fence, mem_instr,
             mem_mode, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
            fails++; $display("FAIL reset_mid: iready=%b irdata=%h mem_valid=%b, all 0 expected",
                              imem_ready, imem_rdata, mem_valid);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_data_priority();
        test_redirect();
        test_spec_same_cycle();
        test_back_to_back();
        test_reset_mid();
        repeat (2) next_cycle();
        tests++;
        if (exp_i.size() != 0 || exp_d.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d imem and %0d dmem responses outstanding, 0 expected",
                              exp_i.size(), exp_d.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-outstanding memory port between instruction fetch (fetch buffer side) and data access (load/store side). Both can be requested in the same cycle.
- Sits between the fetch stage's fetch-buffer/dmem request outputs and the memory/bus interface.
- Serialises transactions, gives data priority, and discards stale speculative instruction responses after a redirect.

Parameters:
- XLEN, 32, address/data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- imem_valid  in  1  instruction request strobe (one cycle per request)
- imem_spec  in  1  request is a redirect; invalidates any in-flight instruction access
- imem_fence  in  1  fence flag, forwarded with the request
- imem_mode  in  2  privilege mode
- imem_addr  in  XLEN  fetch address
- imem_ready  out  1  instruction response valid (one-cycle pulse)
- imem_rdata  out  XLEN  instruction response data
- dmem_valid  in  1  data request strobe
- dmem_mode  in  2  privilege mode
- dmem_addr  in  XLEN  data address
- dmem_wdata  in  XLEN  store data
- dmem_wstrb  in  4  byte strobes; 0 = load
- dmem_ready  out  1  data response valid (one-cycle pulse)
- dmem_rdata  out  XLEN  load data
- mem_valid  out  1  downstream request strobe (one cycle per transaction)
- mem_fence, mem_instr  out  1 each  fence flag; 1 = instruction access
- mem_mode  out  2
- mem_addr, mem_wdata  out  XLEN
- mem_wstrb  out  4
- mem_ready  in  1  downstream completion pulse
- mem_rdata  in  XLEN  downstream read data

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; ipend=0, dpend=0, discard=0.
  - All outputs 0 in the following cycle.
  - Reset mid-transaction drops the transaction; a late mem_ready after reset is ignored while state=IDLE.
- Pending slots:
  - ipend holds {addr, mode, fence}; dpend holds {addr, mode, wdata, wstrb}.
  - A strobe is captured into its slot if it is not issued in the same cycle.
  - A new imem_valid overwrites ipend (latest fetch wins).
  - dmem_valid while dpend=1 is illegal; the data requester stalls until dmem_ready.
- States: IDLE, IBUSY (instruction outstanding), DBUSY (data outstanding).
- Issue slot: a cycle where state=IDLE, or a busy state with mem_ready=1.
- Issue rule in an issue slot (combinational, zero latency):
  - Candidate D = dmem_valid or dpend; candidate I = imem_valid or ipend.
  - Live inputs take precedence over the pending copy of the same requester.
  - D beats I.
  - Issuing drives mem_valid=1 for exactly that cycle, with fields from the chosen source.
  - mem_instr=1 for I, 0 for D. mem_wstrb=0 and mem_fence=imem_fence for I. mem_fence=0 for D.
  - Issuing clears the corresponding pending slot. Next state is IBUSY or DBUSY.
  - If nothing is issued: next state IDLE.
- Completion:
  - DBUSY with mem_ready: dmem_ready=1 and dmem_rdata=mem_rdata in the same cycle (combinational).
  - IBUSY with mem_ready and discard=0: imem_ready=1 and imem_rdata=mem_rdata.
  - IBUSY with mem_ready and discard=1: no imem_ready; discard clears.
- Speculation:
  - imem_valid with imem_spec=1 while state=IBUSY and mem_ready=0 sets discard. The new request waits in ipend.
  - imem_spec=1 in the same cycle as the IBUSY mem_ready: the old response is dropped, discard stays 0, and the new request is issued that cycle (unless D wins).
  - imem_spec has no effect on data transactions.
- Output holding: imem_rdata/dmem_rdata are 0 when the matching ready is 0.
- Starvation: D priority is absolute. Data requests are at most one per instruction, so I always progresses.

Test Plan:
- Idle, imem_valid addr=0x100: mem_valid=1, mem_instr=1, mem_addr=0x100 in the same cycle. mem_ready 2 cycles later with rdata=0x00000013 -> imem_ready=1, imem_rdata=0x13 that cycle.
- Simultaneous imem 0x104 and dmem store 0x2000 (wdata=0xDEADBEEF, wstrb=0xF):
  - Data issues first.
  - On its mem_ready, dmem_ready=1 and the fetch to 0x104 issues in that same cycle (mem_instr=1).
- Redirect while fetch 0x108 outstanding: imem_valid spec=1 addr=0x400 -> 0x108 response suppressed (imem_ready stays 0); 0x400 issues on the completion cycle; its response is delivered.
- Two non-spec imem_valid (0x10C then 0x110) during DBUSY -> only 0x110 issued after data completion.
- Assert rst=0 during IBUSY, then mem_ready pulse after release -> no imem_ready, state IDLE, all outputs 0.
